// File: rtl/serial_frame_decoder.sv
// serial_frame_decoder
//   Serial-to-parallel frame decoder. One bit is sampled per rising clock
//   edge. A frame is a start bit (1), DATA_WIDTH data bits, an optional
//   parity bit and a stop bit (0). The line idles at 0. A good frame updates
//   parallelOut and pulses frameValid. A bad frame pulses parityError or
//   frameError and bumps a saturating error counter. After a framing error
//   the decoder waits for the line to return to 0 before it looks for a
//   new start bit.
//
// Ports
//   clock        in   system clock, rising-edge sampling
//   reset        in   asynchronous active-high reset
//   serialIn     in   serial line (idle 0, start 1, stop 0)
//   parallelOut  out  [DATA_WIDTH] last correctly received word
//   frameValid   out  1-cycle pulse, parallelOut just updated
//   parityError  out  1-cycle pulse, parity mismatch, frame dropped
//   frameError   out  1-cycle pulse, stop bit was 1, frame dropped
//   busy         out  high whenever the decoder is not idle
//   errorCount   out  [ERR_CNT_W] saturating count of error strobes
module serial_frame_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serialIn,
    output logic [DATA_WIDTH-1:0] parallelOut,
    output logic                  frameValid,
    output logic                  parityError,
    output logic                  frameError,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  errorCount
);

    localparam int                   CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic                 ODD_BIT  = (PARITY_ODD != 0);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        RESYNC
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shreg, shreg_next;
    logic [DATA_WIDTH-1:0]   out_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic                    par_ok, par_ok_next;
    logic                    valid_next, perr_next, ferr_next;
    logic [ERR_CNT_W-1:0]    errcnt_next;

    // Insert the newly sampled bit so that the first data bit ends up at
    // the MSB (MSB_FIRST=1) or the LSB (MSB_FIRST=0) after DATA_WIDTH shifts.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] sr,
        input logic                  b
    );
        if (MSB_FIRST != 0)
            return {sr[DATA_WIDTH-2:0], b};
        else
            return {b, sr[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(
        input logic [ERR_CNT_W-1:0] v
    );
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        cnt_next    = cnt;
        par_ok_next = par_ok;
        out_next    = parallelOut;
        valid_next  = 1'b0;
        perr_next   = 1'b0;
        ferr_next   = 1'b0;

        case (state)
            IDLE: begin
                if (serialIn) begin
                    state_next  = DATA;
                    cnt_next    = '0;
                    // Without a parity bit every frame counts as parity-good.
                    par_ok_next = 1'b1;
                end
            end
            DATA: begin
                shreg_next = shift_in(shreg, serialIn);
                cnt_next   = cnt + 1'b1;
                if (cnt == LAST_BIT)
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                par_ok_next = ((^shreg) ^ serialIn) == ODD_BIT;
                state_next  = STOP;
            end
            STOP: begin
                // A bad stop bit wins over a parity failure.
                if (serialIn) begin
                    ferr_next  = 1'b1;
                    state_next = RESYNC;
                end else begin
                    state_next = IDLE;
                    if (par_ok) begin
                        out_next   = shreg;
                        valid_next = 1'b1;
                    end else begin
                        perr_next = 1'b1;
                    end
                end
            end
            RESYNC: begin
                // A high line here is the tail of a broken frame, not a start.
                if (!serialIn)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        errcnt_next = (perr_next || ferr_next) ? sat_inc(errorCount) : errorCount;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            par_ok      <= 1'b0;
            parallelOut <= '0;
            frameValid  <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
            busy        <= 1'b0;
            errorCount  <= '0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            cnt         <= cnt_next;
            par_ok      <= par_ok_next;
            parallelOut <= out_next;
            frameValid  <= valid_next;
            parityError <= perr_next;
            frameError  <= ferr_next;
            busy        <= (state_next != IDLE);
            errorCount  <= errcnt_next;
        end
    end

endmodule

// File: tb/tb_serial_frame_decoder.sv
// tb_serial_frame_decoder
//   Bench for serial_frame_decoder. Three instances share the clock and
//   reset: the default configuration, a 12-bit LSB-first no-parity variant
//   and a 2-bit error-counter variant. Expected values come from a
//   frame-level reference model (last good word, saturating error count).
module tb_serial_frame_decoder;

    logic        clock;
    logic        reset;
    logic        sin, sin_lsb, sin_sat;

    logic [7:0]  po;
    logic        fv, pe, fe, bz;
    logic [7:0]  ec;

    logic [11:0] po_l;
    logic        fv_l, pe_l, fe_l, bz_l;
    logic [7:0]  ec_l;

    logic [7:0]  po_s;
    logic        fv_s, pe_s, fe_s, bz_s;
    logic [1:0]  ec_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state for the default instance
    logic [7:0]  exp_out;
    int          exp_cnt;

    serial_frame_decoder dut (
        .clock(clock), .reset(reset), .serialIn(sin),
        .parallelOut(po), .frameValid(fv), .parityError(pe),
        .frameError(fe), .busy(bz), .errorCount(ec)
    );

    serial_frame_decoder #(
        .DATA_WIDTH(12), .MSB_FIRST(0), .PARITY_EN(0)
    ) dut_lsb (
        .clock(clock), .reset(reset), .serialIn(sin_lsb),
        .parallelOut(po_l), .frameValid(fv_l), .parityError(pe_l),
        .frameError(fe_l), .busy(bz_l), .errorCount(ec_l)
    );

    serial_frame_decoder #(
        .ERR_CNT_W(2)
    ) dut_sat (
        .clock(clock), .reset(reset), .serialIn(sin_sat),
        .parallelOut(po_s), .frameValid(fv_s), .parityError(pe_s),
        .frameError(fe_s), .busy(bz_s), .errorCount(ec_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one bit on the selected line for one edge; returns 1 time unit
    // after that edge so registered outputs can be sampled.
    task automatic drive(input int which, input logic b);
        case (which)
            0: sin     = b;
            1: sin_lsb = b;
            default: sin_sat = b;
        endcase
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input int which, input int width, input logic [31:0] d,
                              input bit msb, input bit pen, input bit pflip,
                              input logic stopb);
        drive(which, 1'b1);
        for (int i = 0; i < width; i++)
            drive(which, d[msb ? (width - 1 - i) : i]);
        if (pen)
            drive(which, (^d) ^ pflip);
        drive(which, stopb);
    endtask

    task automatic do_reset();
        sin = 1'b0; sin_lsb = 1'b0; sin_sat = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_out = 8'h00;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        sin = 1'b0; sin_lsb = 1'b0; sin_sat = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({po, fv, pe, fe, bz, ec} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {po, fv, pe, fe, bz, ec});
        end
        reset = 1'b0;
        exp_out = 8'h00;
        exp_cnt = 0;
        repeat (3) drive(0, 1'b0);
        n_checks++;
        if (bz !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", bz);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] d;
        d = 8'hA5;
        drive(0, 1'b1);
        for (int i = 7; i >= 0; i--) drive(0, d[i]);
        n_checks++;
        if (bz !== 1'b1 || fv !== 1'b0) begin
            n_fail++;
            $display("FAIL good_mid_busy: got busy=%b valid=%b expected 1/0", bz, fv);
        end
        drive(0, 1'b0);  // parity
        drive(0, 1'b0);  // stop
        exp_out = d;
        n_checks++;
        if (po !== exp_out || fv !== 1'b1 || bz !== 1'b0 || ec !== 8'd0) begin
            n_fail++;
            $display("FAIL good_frame: got po=%h fv=%b bz=%b ec=%0d expected %h 1 0 0",
                     po, fv, bz, ec, exp_out);
        end
        drive(0, 1'b0);
        n_checks++;
        if (fv !== 1'b0) begin
            n_fail++;
            $display("FAIL good_pulse_width: got fv=%b expected 0", fv);
        end
    endtask

    task automatic test_parity_error();
        do_reset();
        send_frame(0, 8, 32'hA5, 1, 1, 1, 1'b0);
        exp_cnt = exp_cnt + 1;
        n_checks++;
        if (pe !== 1'b1 || fv !== 1'b0 || po !== 8'h00 || ec !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL parity_error: got pe=%b fv=%b po=%h ec=%0d expected 1 0 00 %0d",
                     pe, fv, po, ec, exp_cnt);
        end
        drive(0, 1'b0);
        n_checks++;
        if (pe !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_pulse_width: got pe=%b expected 0", pe);
        end
    endtask

    task automatic test_frame_error();
        send_frame(0, 8, 32'h3C, 1, 1, 0, 1'b1);
        exp_cnt = exp_cnt + 1;
        n_checks++;
        if (fe !== 1'b1 || fv !== 1'b0 || pe !== 1'b0 || po !== exp_out || ec !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL frame_error: got fe=%b fv=%b pe=%b po=%h ec=%0d expected 1 0 0 %h %0d",
                     fe, fv, pe, po, ec, exp_out, exp_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1);
            n_checks++;
            if (bz !== 1'b1 || fe !== 1'b0 || fv !== 1'b0) begin
                n_fail++;
                $display("FAIL resync_hold[%0d]: got bz=%b fe=%b fv=%b expected 1 0 0", i, bz, fe, fv);
            end
        end
        drive(0, 1'b0);
        n_checks++;
        if (bz !== 1'b0) begin
            n_fail++;
            $display("FAIL resync_release: got bz=%b expected 0", bz);
        end
        send_frame(0, 8, 32'h3C, 1, 1, 0, 1'b0);
        exp_out = 8'h3C;
        n_checks++;
        if (fv !== 1'b1 || po !== exp_out) begin
            n_fail++;
            $display("FAIL after_resync: got fv=%b po=%h expected 1 %h", fv, po, exp_out);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        send_frame(0, 8, 32'h3C, 1, 1, 0, 1'b0);
        t1 = cyc;
        n_checks++;
        if (fv !== 1'b1 || po !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_first: got fv=%b po=%h expected 1 3c", fv, po);
        end
        send_frame(0, 8, 32'hC3, 1, 1, 0, 1'b0);
        t2 = cyc;
        exp_out = 8'hC3;
        n_checks++;
        if (fv !== 1'b1 || po !== exp_out || (t2 - t1) != 11) begin
            n_fail++;
            $display("FAIL b2b_second: got fv=%b po=%h gap=%0d expected 1 c3 11", fv, po, t2 - t1);
        end
    endtask

    task automatic test_reset_mid_frame();
        drive(0, 1'b1);
        for (int i = 0; i < 4; i++) drive(0, 1'b1);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({po, fv, pe, fe, bz, ec} !== 20'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {po, fv, pe, fe, bz, ec});
        end
        sin = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_out = 8'h00;
        exp_cnt = 0;
        send_frame(0, 8, 32'h0F, 1, 1, 0, 1'b0);
        exp_out = 8'h0F;
        n_checks++;
        if (fv !== 1'b1 || po !== exp_out || ec !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_frame: got fv=%b po=%h ec=%0d expected 1 0f 0", fv, po, ec);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         kind, gap, hold;
        bit         good;
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive(0, 1'b0);
            send_frame(0, 8, {24'h0, d}, 1, 1, (kind == 2), (kind == 3) ? 1'b1 : 1'b0);
            good = (kind < 2);
            if (good) exp_out = d;
            else if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
            n_checks++;
            if (fv !== good || pe !== (kind == 2) || fe !== (kind == 3) ||
                po !== exp_out || ec !== 8'(exp_cnt)) begin
                n_fail++;
                $display("FAIL random[%0d] d=%h kind=%0d: got fv=%b pe=%b fe=%b po=%h ec=%0d expected po=%h ec=%0d",
                         n, d, kind, fv, pe, fe, po, ec, exp_out, exp_cnt);
            end
            if (kind == 3) begin
                hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) drive(0, 1'b1);
                drive(0, 1'b0);
                n_checks++;
                if (bz !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_resync[%0d]: got bz=%b expected 0", n, bz);
                end
            end
        end
    endtask

    task automatic test_lsb_variant();
        logic [11:0] d;
        do_reset();
        send_frame(1, 12, 32'h001, 0, 0, 0, 1'b0);
        n_checks++;
        if (fv_l !== 1'b1 || po_l !== 12'h001) begin
            n_fail++;
            $display("FAIL lsb_frame: got fv=%b po=%h expected 1 001", fv_l, po_l);
        end
        d = 12'($urandom);
        send_frame(1, 12, {20'h0, d}, 0, 0, 0, 1'b0);
        n_checks++;
        if (fv_l !== 1'b1 || po_l !== d) begin
            n_fail++;
            $display("FAIL lsb_random: got fv=%b po=%h expected 1 %h", fv_l, po_l, d);
        end
        send_frame(1, 12, 32'hABC, 0, 0, 0, 1'b1);
        n_checks++;
        if (fe_l !== 1'b1 || po_l !== d || ec_l !== 8'd1) begin
            n_fail++;
            $display("FAIL lsb_stop_error: got fe=%b po=%h ec=%0d expected 1 %h 1", fe_l, po_l, ec_l, d);
        end
        drive(1, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            send_frame(2, 8, 32'($urandom_range(0, 255)), 1, 1, 1, 1'b0);
            n_checks++;
            if (pe_s !== 1'b1 || ec_s !== 2'((k > 3) ? 3 : k)) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got pe=%b ec=%0d expected 1 %0d",
                         k, pe_s, ec_s, (k > 3) ? 3 : k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_lsb_variant();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
